// File: rtl/gcd_dispatcher.sv
// gcd_dispatcher: queues operand pairs and drives one iterative GCD engine.
// Optional engine timeout/abort path is enabled by GCD_DISPATCH_TIMEOUT_EN.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o       command handshake (ready = FIFO not full)
//   cmd_a_i, cmd_b_i, cmd_tag_i   operands and opaque tag
//   rsp_valid_o/rsp_ready_i       response handshake
//   rsp_gcd_o, rsp_tag_o          result and tag of its command
//   rsp_err_o                     engine timed out (gcd forced to 0)
//   core_in1_o, core_in2_o        engine operands, held for the whole job
//   core_go_o, core_done_i        engine start pulse / completion pulse
//   core_out_i                    engine result, valid after core_done_i
//   core_rst_o                    engine reset (rst or abort pulse)
//   busy_o                        job in flight or commands queued
module gcd_dispatcher #(
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [DW-1:0] cmd_a_i,
    input  logic [DW-1:0] cmd_b_i,
    input  logic [3:0]    cmd_tag_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_gcd_o,
    output logic [3:0]    rsp_tag_o,
    output logic          rsp_err_o,
    output logic [DW-1:0] core_in1_o,
    output logic [DW-1:0] core_in2_o,
    output logic          core_go_o,
    input  logic          core_done_i,
    input  logic [DW-1:0] core_out_i,
    output logic          core_rst_o,
    output logic          busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
`ifdef GCD_DISPATCH_TIMEOUT_EN
        S_ABORT,
`endif
        S_RESP
    } state_t;

    logic [DW-1:0] mem_a [FIFO_DEPTH];
    logic [DW-1:0] mem_b [FIFO_DEPTH];
    logic [3:0]    mem_t [FIFO_DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          full, empty, push, pop;
    logic [DW-1:0] head_a, head_b;
    logic [3:0]    head_t;

    state_t        state_q;
    logic [DW-1:0] ja_q, jb_q;
    logic [DW-1:0] rsp_gcd_q;
    logic [3:0]    rsp_tag_q;
    logic          rsp_valid_q;
    logic          go_q;

    // Extra pointer bit distinguishes full from empty on equal indices.
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign push  = cmd_valid_i && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    assign wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    assign rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;

    assign head_a = mem_a[rptr_q[AW-1:0]];
    assign head_b = mem_b[rptr_q[AW-1:0]];
    assign head_t = mem_t[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wptr_q[AW-1:0]] <= cmd_a_i;
            mem_b[wptr_q[AW-1:0]] <= cmd_b_i;
            mem_t[wptr_q[AW-1:0]] <= cmd_tag_i;
        end
    end

`ifdef GCD_DISPATCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q;
    logic          rsp_err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ja_q        <= '0;
            jb_q        <= '0;
            rsp_gcd_q   <= '0;
            rsp_tag_q   <= '0;
            rsp_valid_q <= 1'b0;
            go_q        <= 1'b0;
`ifdef GCD_DISPATCH_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            go_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        ja_q      <= head_a;
                        jb_q      <= head_b;
                        rsp_tag_q <= head_t;
                        // A zero operand would never terminate in the
                        // engine; a|b is the answer for those cases.
                        if (head_a == '0 || head_b == '0) begin
                            rsp_gcd_q   <= head_a | head_b;
                            rsp_valid_q <= 1'b1;
`ifdef GCD_DISPATCH_TIMEOUT_EN
                            rsp_err_q   <= 1'b0;
`endif
                            state_q     <= S_RESP;
                        end else begin
                            go_q    <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
`ifdef GCD_DISPATCH_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done_i) begin
                        state_q <= S_CAPTURE;
`ifdef GCD_DISPATCH_TIMEOUT_EN
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q <= S_ABORT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
`endif
                    end
                end
                S_CAPTURE: begin
                    rsp_gcd_q   <= core_out_i;
                    rsp_valid_q <= 1'b1;
`ifdef GCD_DISPATCH_TIMEOUT_EN
                    rsp_err_q   <= 1'b0;
`endif
                    state_q     <= S_RESP;
                end
`ifdef GCD_DISPATCH_TIMEOUT_EN
                S_ABORT: begin
                    rsp_gcd_q   <= '0;
                    rsp_err_q   <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
`endif
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef GCD_DISPATCH_TIMEOUT_EN
    assign rsp_err_o  = rsp_err_q;
    assign core_rst_o = rst | (state_q == S_ABORT);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign rsp_err_o  = 1'b0;
    assign core_rst_o = rst;
`endif

    assign cmd_ready_o = !full;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_gcd_o   = rsp_gcd_q;
    assign rsp_tag_o   = rsp_tag_q;
    assign core_in1_o  = ja_q;
    assign core_in2_o  = jb_q;
    assign core_go_o   = go_q;
    assign busy_o      = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_gcd_dispatcher.sv
// Scoreboard bench for gcd_dispatcher with a behavioural GCD engine.
// Expected responses come from a Euclid reference model in the bench.
module tb_gcd_dispatcher;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic [3:0]    cmd_tag = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_gcd;
    logic [3:0]    rsp_tag;
    logic          rsp_err;
    logic [DW-1:0] core_in1, core_in2;
    logic          core_go;
    logic          eng_done = 1'b0;
    logic          extra_done = 1'b0;
    logic          core_done;
    logic [DW-1:0] eng_out = '0;
    logic          core_rst;
    logic          busy;

    assign core_done = eng_done | extra_done;

    always #5 clk = ~clk;

    gcd_dispatcher #(.DW(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_tag_i(cmd_tag),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_gcd_o(rsp_gcd), .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err),
        .core_in1_o(core_in1), .core_in2_o(core_in2),
        .core_go_o(core_go), .core_done_i(core_done),
        .core_out_i(eng_out), .core_rst_o(core_rst), .busy_o(busy)
    );

    typedef struct packed {
        logic [DW-1:0] gcd;
        logic [3:0]    tag;
        logic          err;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   go_cnt = 0;
    int   exp_go = 0;
    int   rst_pulses = 0;
    bit   eng_en = 1'b1;
    int   k_lo = 1;
    int   k_hi = 6;
    int   ready_mode = 1;

    function automatic logic [DW-1:0] ref_gcd(logic [DW-1:0] a,
                                              logic [DW-1:0] b);
        logic [DW-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // 0: hold low, 1: hold high, 2: random backpressure
    always @(negedge clk) begin
        if (ready_mode == 2) rsp_ready = ($urandom_range(0, 9) < 7);
        else                 rsp_ready = (ready_mode == 1);
    end

    // Behavioural engine: latches operands on go, answers after k cycles.
    always begin
        @(negedge clk);
        if (core_go) begin
            go_cnt++;
            if (eng_en) begin
                logic [DW-1:0] a, b;
                int k, i;
                bit aborted;
                a = core_in1;
                b = core_in2;
                chk("go_nonzero_ops", 64'(a != 0 && b != 0), 64'd1);
                k = $urandom_range(k_lo, k_hi);
                i = 0;
                aborted = 1'b0;
                while (i < k && !aborted) begin
                    @(negedge clk);
                    if (core_rst) aborted = 1'b1;
                    else chk("ops_stable", {core_in1, core_in2}, {a, b});
                    i++;
                end
                if (!aborted) begin
                    eng_out  = ref_gcd(a, b);
                    eng_done = 1'b1;
                    @(negedge clk);
                    eng_done = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expectations on each response handshake.
    rsp_t held_r;
    bit   held = 1'b0;
    always begin
        rsp_t e;
        @(negedge clk);
        #2;
        if (!rst && core_rst) rst_pulses++;
        if (rsp_valid) begin
            if (held) chk("rsp_stable", {rsp_gcd, rsp_tag, rsp_err}, held_r);
            if (rsp_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp actual=%0h/%0h required=none",
                             rsp_gcd, rsp_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_gcd", 64'(rsp_gcd), 64'(e.gcd));
                    chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end else begin
                held   = 1'b1;
                held_r = {rsp_gcd, rsp_tag, rsp_err};
            end
        end else begin
            held = 1'b0;
        end
    end

    function automatic void expect_rsp(logic [DW-1:0] a, logic [DW-1:0] b,
                                       logic [3:0] t, bit tmo);
        rsp_t e;
        e.gcd = tmo ? '0 : ref_gcd(a, b);
        e.tag = t;
        e.err = tmo;
        exp_q.push_back(e);
        if (a != 0 && b != 0) exp_go++;
    endfunction

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [3:0] t, input bit tmo);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_tag = t;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL push_timeout actual=stuck required=accept");
        end else begin
            expect_rsp(a, b, t, tmo);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || rsp_valid || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 64'(n < 3000), 64'd1);
    endtask

    task automatic check_reset_outputs(string tagn);
        chk({tagn, "_core_rst"}, 64'(core_rst), 64'd1);
        chk({tagn, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tagn, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tagn, "_rsp_gcd"}, 64'(rsp_gcd), 64'd0);
        chk({tagn, "_rsp_tag"}, 64'(rsp_tag), 64'd0);
        chk({tagn, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({tagn, "_core_go"}, 64'(core_go), 64'd0);
        chk({tagn, "_core_in"}, {core_in1, core_in2}, 64'd0);
        chk({tagn, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] sa [6];
        logic [DW-1:0] sb [6];
        int acc, n;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // basic engine job
        push(12, 18, 3, 0);
        wait_idle();
        chk("go_count_basic", 64'(go_cnt), 64'd1);

        // zero-operand bypass and its one-cycle latency
        push(0, 7, 1, 0);
        chk("bypass_lat_pop", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("bypass_lat_rsp", 64'(rsp_valid), 64'd1);
        wait_idle();
        push(9, 0, 2, 0);
        @(negedge clk);
        chk("bypass_lat_rsp2", 64'(rsp_valid), 64'd1);
        push(0, 0, 5, 0);
        wait_idle();
        chk("go_count_bypass", 64'(go_cnt), 64'd1);

        // backpressure: FIFO_DEPTH queued plus one job in flight
        ready_mode = 0;
        for (int i = 0; i < 6; i++) begin
            sa[i] = $urandom_range(1, 300);
            sb[i] = $urandom_range(1, 300);
        end
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            cmd_valid = 1'b1;
            cmd_a = sa[acc];
            cmd_b = sb[acc];
            cmd_tag = 4'(acc + 8);
            if (cmd_ready) begin
                expect_rsp(sa[acc], sb[acc], 4'(acc + 8), 0);
                acc++;
            end
            @(negedge clk);
            if (acc == 5) cmd_valid = 1'b1;
        end
        chk("stall_accepted", 64'(acc), 64'(DEPTH + 1));
        chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        cmd_valid = 1'b0;
        ready_mode = 1;
        push(sa[5], sb[5], 4'd13, 0);
        wait_idle();
        chk("go_count_stall", 64'(go_cnt), 64'(exp_go));

        // core_done while a response is waiting is ignored
        ready_mode = 0;
        push(12, 18, 7, 0);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("resp_reached", 64'(rsp_valid), 64'd1);
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        repeat (3) @(negedge clk);
        ready_mode = 1;
        wait_idle();
        repeat (10) @(negedge clk);
        chk("go_count_stray_done", 64'(go_cnt), 64'(exp_go));

        // reset during WAIT with commands queued
        k_lo = 40;
        k_hi = 40;
        push(21, 14, 1, 0);
        push(8, 4, 2, 0);
        push(9, 6, 3, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp_go = exp_go - 2;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        k_lo = 1;
        k_hi = 6;
        repeat (50) @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(cmd_ready), 64'd1);
        chk("go_count_midrst", 64'(go_cnt), 64'(exp_go));

`ifdef GCD_DISPATCH_TIMEOUT_EN
        eng_en = 1'b0;
        push(5, 3, 4, 1);
        n = 0;
        while (!core_go && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!core_rst && n < 40);
        chk("tmo_wait_cycles", 64'(n), 64'(TMO + 1));
        @(negedge clk);
        chk("tmo_rst_one_cycle", 64'(core_rst), 64'd0);
        wait_idle();
        eng_en = 1'b1;
        push(8, 12, 6, 0);
        wait_idle();
        chk("tmo_abort_pulses", 64'(rst_pulses), 64'd1);
`else
        chk("no_abort_pulses", 64'(rst_pulses), 64'd0);
`endif

        // randomized traffic with random backpressure
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] a, b;
            a = ($urandom_range(0, 5) == 0) ? '0 : $urandom_range(1, 5000);
            b = ($urandom_range(0, 5) == 0) ? '0 : $urandom_range(1, 5000);
            if ($urandom_range(0, 3) == 0) b = a * $urandom_range(1, 7);
            push(a, b, 4'($urandom_range(0, 15)), 0);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end
        ready_mode = 1;
        wait_idle();
        chk("go_count_random", 64'(go_cnt), 64'(exp_go));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcd_dispatcher.md
# gcd_dispatcher

Host-side initiator for the iterative GCD engine. Accepts operand pairs over a valid/ready command port and buffers them in a small FIFO. Drives each pair into the engine's go/done handshake, or bypasses the engine for zero operands, and returns tagged results over a valid/ready response port. It sits between a bus-facing command source and one GCD engine instance, and owns that engine's reset.

## Interface
- DW, 32, operand/result width; must match the engine.
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2.
- TIMEOUT, 4096, maximum WAIT cycles before abort (used only with the timeout feature).
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_a, cmd_b  in  DW  operands.
- cmd_tag  in  4  opaque ID, returned with the result.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_gcd  out  DW  result.
- rsp_tag  out  4  tag of the command.
- rsp_err  out  1  engine timed out; rsp_gcd=0.
- core_in1, core_in2  out  DW  engine operands; held stable for the whole job.
- core_go  out  1  one-cycle start pulse.
- core_done  in  1  engine completion pulse.
- core_out  in  DW  engine result register; valid the cycle after core_done.
- core_rst  out  1  engine reset = rst | abort pulse.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

## Operation
- A push happens when cmd_valid && cmd_ready; it writes {a,b,tag} at the write pointer.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH.
  - full: MSBs differ and the rest are equal.
  - empty: the pointers are equal.
- Pushing while full cannot happen, because cmd_ready is low when full.
- A pop happens only in IDLE with the FIFO non-empty.
- A same-cycle push and pop is legal; the occupancy is unchanged.
- The popped entry loads the job registers ja, jb, jtag. core_in1/core_in2 always drive ja/jb.
- FSM states:
  - IDLE: on pop, if ja==0 or jb==0 go to RESP with result ja|jb (so gcd(0,0)=0). Otherwise go to ISSUE. The engine is never started with a zero operand, because it would not terminate.
  - ISSUE: core_go=1 for exactly one cycle, then WAIT.
  - WAIT: on core_done=1 go to CAPTURE. A core_done seen in any other state is ignored.
  - CAPTURE: register rsp_gcd←core_out and rsp_err←0, then RESP.
  - RESP: rsp_valid=1. rsp_gcd, rsp_tag and rsp_err are stable until rsp_ready=1. On rsp_ready go to IDLE; the next pop happens in that IDLE cycle at the earliest.
  - ABORT (feature only): core_rst=1 for one cycle; rsp_gcd←0 and rsp_err←1; then RESP.
- Reset values:
  - cmd_ready=1 after reset.
  - rsp_valid=0, rsp_gcd=0, rsp_tag=0, rsp_err=0.
  - core_go=0, core_in1/in2=0, busy=0.
  - core_rst=1 during rst.
  - The FIFO is emptied and the FSM returns to IDLE.
- A reset mid-job discards the in-flight job and all queued commands. No response is produced for them.

## Timing
- Zero-operand bypass: pop in IDLE at edge N, rsp_valid at N+1.
- Engine path: pop at N, core_go high during cycle N+1, core_done arrives k cycles later.
  - CAPTURE runs the cycle after core_done.
  - rsp_valid asserts the cycle after CAPTURE.
- Sustained throughput: one job per response handshake. There is no overlap of jobs in the engine.
- cmd_ready is combinational from the pointers only; it never depends on cmd_valid.

## Configuration
- GCD_DISPATCH_TIMEOUT_EN defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without core_done, go to ABORT.
  - If core_done arrives in the same cycle, core_done wins.
- GCD_DISPATCH_TIMEOUT_EN undefined:
  - No counter and no ABORT state.
  - WAIT is unbounded.
  - rsp_err is constant 0.
  - core_rst equals rst.

## Test plan
- Push (12,18,tag 3) with a behavioural engine model → exactly one core_go pulse; response rsp_gcd=6, rsp_tag=3, rsp_err=0.
- Push (0,7) then (9,0) → no core_go; responses 7 then 9, each rsp_valid 1 cycle after its pop; (0,0) returns 0.
- Hold rsp_ready=0 and push 6 commands → cmd_ready drops after FIFO_DEPTH accepted plus the one in flight. Responses return in order with correct tags, and outputs stay stable while stalled.
- Timeout build, TIMEOUT=16, core_done tied 0, push (5,3) → ABORT after 16 WAIT cycles, core_rst high 1 cycle, response rsp_gcd=0 and rsp_err=1; the next command then completes normally.
- Assert rst for 1 cycle during WAIT with 2 commands queued → all outputs at reset values, no responses, cmd_ready=1, busy=0.
- Pulse core_done while in RESP → ignored; no extra response.
